// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states and owner IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LOAD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: on contention the port that was not
// served last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      grant = (last == OWN_CORE) ? OWN_LOAD : OWN_CORE;
    end else begin
      grant = req[1] ? OWN_LOAD : OWN_CORE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's unified instruction/data memory between the core controller
// and the loader; one transaction at a time, round-robin, fixed read latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  arb_state_t state;
  logic       last_owner;
  logic [3:0] cnt;
  logic       win;
  logic       win_valid;

  rr_pick2 u_pick (
    .req   ({d_req, c_req}),
    .last  (last_owner),
    .grant (win),
    .valid (win_valid)
  );

  // mem_we/mem_addr/mem_wdata double as the latched request; mem_we is only
  // cleared after ISSUE has consumed it to pick the write or read path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_owner <= OWN_LOAD;
      cnt        <= '0;
      owner      <= OWN_CORE;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            owner     <= win;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= (win == OWN_LOAD) ? d_we    : c_we;
            mem_addr  <= (win == OWN_LOAD) ? d_addr  : c_addr;
            mem_wdata <= (win == OWN_LOAD) ? d_wdata : c_wdata;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= '0;
          if (mem_we) begin
            c_ack <= (owner == OWN_CORE);
            d_ack <= (owner == OWN_LOAD);
            state <= ARB_RESP;
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt + 4'd1 == LAT) begin
            if (owner == OWN_LOAD) d_rdata <= mem_rdata;
            else                   c_rdata <= mem_rdata;
            c_ack <= (owner == OWN_CORE);
            d_ack <= (owner == OWN_LOAD);
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          c_ack      <= 1'b0;
          d_ack      <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one instance at MEM_LAT=2,
// one at MEM_LAT=4 for the mid-read reset case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
  logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        c_req4, c_ack4, d_ack4, mem_en4, mem_we4, busy4, owner4;
  logic [31:0] c_addr4, c_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .c_req(c_req4), .c_we(zero1), .c_addr(c_addr4), .c_wdata(zero32),
    .c_ack(c_ack4), .c_rdata(c_rdata4),
    .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_ack(d_ack4), .d_rdata(d_rdata4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4), .owner(owner4)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'hA5A5_0000) + 32'h100);
  endfunction

  // Memory models: read data is valid only MEM_LAT cycles after the mem_en cycle.
  logic [1:0]  v2;
  logic [31:0] a2 [2];
  logic [3:0]  v4;
  logic [31:0] a4 [4];

  always @(posedge clk) begin
    v2[0] <= mem_en && !mem_we;
    a2[0] <= mem_addr;
    v2[1] <= v2[0];
    a2[1] <= a2[0];
    v4[0] <= mem_en4 && !mem_we4;
    a4[0] <= mem_addr4;
    for (int i = 1; i < 4; i++) begin
      v4[i] <= v4[i-1];
      a4[i] <= a4[i-1];
    end
  end

  assign mem_rdata  = v2[1] ? mem_val(a2[1]) : 32'hBAD0_BAD0;
  assign mem_rdata4 = v4[3] ? mem_val(a4[3]) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nc, nd, na;
    rst = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    c_req4 = 0; c_addr4 = '0;
    repeat (2) @(negedge clk);

    chk("rst_ctl", {26'd0, mem_en, mem_we, busy, owner, c_ack, d_ack}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst4_ctl", {28'd0, mem_en4, busy4, c_ack4, d_ack4}, 32'd0);
    rst = 1'b1;

    // 1: core read at 0x10, MEM_LAT=2 -> ack at T+4
    @(negedge clk);
    c_addr = 32'h10; c_we = 1'b0; c_req = 1'b1;
    chk("t1_en_0", 32'(mem_en), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_en_%0d", k), 32'(mem_en), (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t1_cack_%0d", k), 32'(c_ack), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t1_dack_%0d", k), 32'(d_ack), 32'd0);
      if (k == 1) begin
        chk("t1_we", 32'(mem_we), 32'd0);
        chk("t1_addr", mem_addr, 32'h10);
      end
      if (k == 4) begin
        chk("t1_rdata", c_rdata, 32'hDEAD_BEEF);
        c_req = 1'b0;
      end
    end

    // 2: loader write -> ack at T+2, rdata registers untouched
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234; d_req = 1'b1;
    @(negedge clk);
    chk("t2_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("t2_addr", mem_addr, 32'h20);
    chk("t2_wdata", mem_wdata, 32'h1234);
    chk("t2_owner", {30'd0, busy, owner}, 32'd3);
    @(negedge clk);
    chk("t2_acks", {30'd0, c_ack, d_ack}, 32'd1);
    chk("t2_en_off", 32'(mem_en), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    chk("t2_dack_pulse", 32'(d_ack), 32'd0);
    chk("t2_c_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("t2_d_rdata", d_rdata, 32'd0);

    // 3: simultaneous writes after reset -> C, D, then C again
    do_reset();
    @(negedge clk);
    c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hC0C0;
    d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hD0D0;
    c_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_acks_%0d", k), {30'd0, c_ack, d_ack},
          (k == 2) ? 32'd2 : (k == 5) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("t3_own_c", 32'(owner), 32'd0);
        chk("t3_addr_c", mem_addr, 32'h40);
      end
      if (k == 4) begin
        chk("t3_own_d", 32'(owner), 32'd1);
        chk("t3_addr_d", mem_addr, 32'h44);
        chk("t3_wdata_d", mem_wdata, 32'hD0D0);
      end
      if (k == 2) c_req = 1'b0;
      if (k == 5) d_req = 1'b0;
    end
    @(negedge clk);
    c_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t3b_acks_%0d", k), {30'd0, c_ack, d_ack},
          (k == 2) ? 32'd2 : 32'd0);
      if (k == 2) begin
        c_req = 1'b0;
        d_req = 1'b0;
      end
      if (k == 4) chk("t3b_idle", 32'(busy), 32'd0);
    end

    // 4: both requesting continuously -> strict alternation starting with C
    do_reset();
    @(negedge clk);
    c_we = 1'b0; c_addr = 32'h100;
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
    c_req = 1'b1; d_req = 1'b1;
    nc = 0; nd = 0; na = 0;
    for (int cyc = 0; cyc < 200 && !(nc == 6 && nd == 6); cyc++) begin
      @(negedge clk);
      if (c_ack || d_ack) begin
        chk($sformatf("t4_order_%0d", na), {30'd0, c_ack, d_ack},
            (na % 2 == 0) ? 32'd2 : 32'd1);
        na++;
        if (c_ack) begin
          chk($sformatf("t4_crd_%0d", nc), c_rdata, mem_val(c_addr));
          nc++;
          if (nc == 6) c_req = 1'b0;
          else c_addr = c_addr + 32'd4;
        end
        if (d_ack) begin
          nd++;
          if (nd == 6) d_req = 1'b0;
          else begin
            d_addr = d_addr + 32'd4;
            d_wdata = d_wdata + 32'd1;
          end
        end
      end
    end
    chk("t4_c_count", nc, 32'd6);
    chk("t4_d_count", nd, 32'd6);

    // 6: address change during WAIT does not disturb the latched read
    @(negedge clk);
    c_we = 1'b0; c_addr = 32'h10; c_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6_addr_%0d", k), mem_addr, 32'h10);
      chk($sformatf("t6_cack_%0d", k), 32'(c_ack), (k == 4) ? 32'd1 : 32'd0);
      if (k == 2) c_addr = 32'h50;
      if (k == 4) begin
        chk("t6_rdata", c_rdata, 32'hDEAD_BEEF);
        c_req = 1'b0;
      end
    end

    // 5: reset mid-WAIT at MEM_LAT=4 abandons the read; req then served afresh
    @(negedge clk);
    c_addr4 = 32'h30; c_req4 = 1'b1;
    @(negedge clk);
    chk("t5_en", 32'(mem_en4), 32'd1);
    @(negedge clk);
    chk("t5_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rst_ctl", {28'd0, mem_en4, busy4, c_ack4, d_ack4}, 32'd0);
    chk("t5_rst_addr", mem_addr4, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_rst_ack_%0d", k), {30'd0, c_ack4, busy4}, 32'd0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_cack_%0d", k), 32'(c_ack4), (k == 6) ? 32'd1 : 32'd0);
      if (k == 1) chk("t5_en2", 32'(mem_en4), 32'd1);
      if (k == 5) chk("t5_rd_pre", c_rdata4, 32'd0);
      if (k == 6) begin
        chk("t5_rdata", c_rdata4, mem_val(32'h30));
        c_req4 = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
